// File: rtl/state_ram_pkg.sv
// Shared encodings for the state-RAM read-modify-write arbiter: operation
// codes and controller FSM states.
package state_ram_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    OP_READ      = 2'b00,
    OP_WRITE     = 2'b01,
    OP_INCREMENT = 2'b10,
    OP_CLEAR     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_RD   = 2'b10,
    ST_WB   = 2'b11
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer names the requester
// favoured on a tie and advances only when a grant is issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (enable) begin
      if (req[0] && req[1]) begin
        grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
      // After granting requester 0 favour 1, and vice versa.
      if (grant != 2'b00) begin
        ptr_d = grant[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/state_ram_rmw_arbiter.sv
// Arbitrates two requesters onto a state RAM and performs READ / WRITE /
// INCREMENT / CLEAR as a read-modify-write: accept, read, write back.
module state_ram_rmw_arbiter
  import state_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 1,
  parameter int DATA_WIDTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_address,
  input  logic [1:0]               req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_writedata,
  output logic                     req0_ready,
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_readdata,

  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_address,
  input  logic [1:0]               req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_writedata,
  output logic                     req1_ready,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_readdata,

  output logic [ADDRESS_WIDTH-1:0] ram_wr_address,
  output logic [DATA_WIDTH-1:0]    ram_wr_writedata,
  output logic                     ram_wr_write,
  input  logic                     ram_wr_waitrequest,

  output logic [ADDRESS_WIDTH-1:0] ram_rd0_address,
  input  logic [DATA_WIDTH-1:0]    ram_rd0_readdata,

  output logic                     busy
);

  state_e                   state_q,  state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,   addr_d;
  op_e                      op_q,     op_d;
  logic [DATA_WIDTH-1:0]    wdata_q,  wdata_d;
  logic                     id_q,     id_d;
  logic                     wb_first_q, wb_first_d;
  logic [DATA_WIDTH-1:0]    old_q,    old_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data_d;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               arb_enable;
  logic               wr_write;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH-1:0] new_val;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (arb_enable),
    .req     ({req1_valid, req0_valid}),
    .grant   (grant)
  );

  // RAM data is only valid in the first WB cycle; a stalled write reuses the latched copy.
  always_comb begin
    old_val = wb_first_q ? ram_rd0_readdata : old_q;
    case (op_q)
      OP_WRITE:     new_val = wdata_q;
      OP_INCREMENT: new_val = old_val + DATA_WIDTH'(1);
      OP_CLEAR:     new_val = '0;
      default:      new_val = old_val;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    id_d       = id_q;
    wb_first_d = 1'b0;
    old_d      = old_q;
    arb_enable = 1'b0;
    rsp_valid  = '0;
    wr_write   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (!ram_wr_waitrequest) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        arb_enable = 1'b1;
        if (grant != '0) begin
          id_d    = grant[1];
          addr_d  = grant[1] ? req1_address : req0_address;
          op_d    = op_e'(grant[1] ? req1_op : req0_op);
          wdata_d = grant[1] ? req1_writedata : req0_writedata;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        wb_first_d = 1'b1;
        state_d    = ST_WB;
      end
      ST_WB: begin
        old_d = old_val;
        if (op_q == OP_READ) begin
          rsp_valid[id_q] = 1'b1;
          state_d         = ST_IDLE;
        end else begin
          wr_write = 1'b1;
          if (!ram_wr_waitrequest) begin
            rsp_valid[id_q] = 1'b1;
            state_d         = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Response data passes through on the pulse and is held afterwards.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_data_d[gi] = rsp_valid[gi] ? old_val : rsp_data_q[gi];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      addr_q     <= '0;
      op_q       <= OP_READ;
      wdata_q    <= '0;
      id_q       <= 1'b0;
      wb_first_q <= 1'b0;
      old_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      id_q       <= id_d;
      wb_first_q <= wb_first_d;
      old_q      <= old_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign req0_ready       = grant[0];
  assign req1_ready       = grant[1];
  assign rsp0_valid       = rsp_valid[0];
  assign rsp1_valid       = rsp_valid[1];
  assign rsp0_readdata    = rsp_data_d[0];
  assign rsp1_readdata    = rsp_data_d[1];
  assign ram_wr_write     = wr_write;
  assign ram_wr_address   = wr_write ? addr_q : '0;
  assign ram_wr_writedata = wr_write ? new_val : '0;
  assign ram_rd0_address  = addr_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_state_ram_rmw_arbiter.sv
// Directed bench for state_ram_rmw_arbiter with a small registered-read state RAM model.
module tb_state_ram_rmw_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic       req0_address, req1_address;
  logic [1:0] req0_op, req1_op;
  logic [1:0] req0_writedata, req1_writedata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [1:0] rsp0_readdata, rsp1_readdata;
  logic       ram_wr_address;
  logic [1:0] ram_wr_writedata;
  logic       ram_wr_write;
  logic       ram_wr_waitrequest;
  logic       ram_rd0_address;
  logic [1:0] ram_rd0_readdata;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] last_rsp [2];
  logic [1:0] mem [0:1] = '{2'd3, 2'd0};

  always #5 clk = ~clk;

  state_ram_rmw_arbiter dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req0_valid         (req0_valid),
    .req0_address       (req0_address),
    .req0_op            (req0_op),
    .req0_writedata     (req0_writedata),
    .req0_ready         (req0_ready),
    .rsp0_valid         (rsp0_valid),
    .rsp0_readdata      (rsp0_readdata),
    .req1_valid         (req1_valid),
    .req1_address       (req1_address),
    .req1_op            (req1_op),
    .req1_writedata     (req1_writedata),
    .req1_ready         (req1_ready),
    .rsp1_valid         (rsp1_valid),
    .rsp1_readdata      (rsp1_readdata),
    .ram_wr_address     (ram_wr_address),
    .ram_wr_writedata   (ram_wr_writedata),
    .ram_wr_write       (ram_wr_write),
    .ram_wr_waitrequest (ram_wr_waitrequest),
    .ram_rd0_address    (ram_rd0_address),
    .ram_rd0_readdata   (ram_rd0_readdata),
    .busy               (busy)
  );

  // State RAM: one-cycle registered read with write bypass.
  always @(posedge clk) begin
    if (ram_wr_write && !ram_wr_waitrequest) begin
      mem[ram_wr_address] <= ram_wr_writedata;
    end
    if (ram_wr_write && !ram_wr_waitrequest && ram_wr_address == ram_rd0_address) begin
      ram_rd0_readdata <= ram_wr_writedata;
    end else begin
      ram_rd0_readdata <= mem[ram_rd0_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from the IDLE cycle through WB; g is the expected grantee.
  task automatic run_op(input bit v0, input bit v1, input int g, input logic [1:0] exp_old,
                        input bit exp_wr, input logic ea, input logic [1:0] ed, input bit keep);
    @(negedge clk);
    req0_valid = v0;
    req1_valid = v1;
    #1;
    chk("idle_ready0", req0_ready, (g == 0) ? 1 : 0);
    chk("idle_ready1", req1_ready, (g == 1) ? 1 : 0);
    chk("idle_busy", busy, 0);
    chk("idle_rsp0_valid", rsp0_valid, 0);
    chk("idle_rsp1_valid", rsp1_valid, 0);
    chk("idle_rsp0_hold", rsp0_readdata, last_rsp[0]);
    chk("idle_rsp1_hold", rsp1_readdata, last_rsp[1]);
    @(negedge clk);
    if (!keep) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    #1;
    chk("rd_ready0", req0_ready, 0);
    chk("rd_ready1", req1_ready, 0);
    chk("rd_busy", busy, 1);
    chk("rd_rsp0_valid", rsp0_valid, 0);
    chk("rd_rsp1_valid", rsp1_valid, 0);
    chk("rd_wr_write", ram_wr_write, 0);
    chk("rd_address", ram_rd0_address, ea);
    @(negedge clk);
    #1;
    chk("wb_rsp0_valid", rsp0_valid, (g == 0) ? 1 : 0);
    chk("wb_rsp1_valid", rsp1_valid, (g == 1) ? 1 : 0);
    chk("wb_rsp0_data", rsp0_readdata, (g == 0) ? exp_old : last_rsp[0]);
    chk("wb_rsp1_data", rsp1_readdata, (g == 1) ? exp_old : last_rsp[1]);
    chk("wb_ready0", req0_ready, 0);
    chk("wb_ready1", req1_ready, 0);
    chk("wb_wr_write", ram_wr_write, exp_wr);
    if (exp_wr) begin
      chk("wb_wr_address", ram_wr_address, ea);
      chk("wb_wr_data", ram_wr_writedata, ed);
    end
    last_rsp[g] = exp_old;
    $display("op grant=%0d addr=%0d old=%0d write=%0d data=%0d", g, ea, exp_old, exp_wr, ed);
  endtask

  initial begin
    last_rsp[0] = 2'd0;
    last_rsp[1] = 2'd0;
    reset_n = 1'b0;
    ram_wr_waitrequest = 1'b1;
    req0_valid = 1'b1; req0_address = 1'b0; req0_op = 2'b00; req0_writedata = 2'd0;
    req1_valid = 1'b0; req1_address = 1'b0; req1_op = 2'b00; req1_writedata = 2'd0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_readdata, 0);
    chk("rst_rsp1_data", rsp1_readdata, 0);
    chk("rst_wr_write", ram_wr_write, 0);
    chk("rst_wr_address", ram_wr_address, 0);
    chk("rst_wr_data", ram_wr_writedata, 0);
    chk("rst_rd_address", ram_rd0_address, 0);
    chk("rst_busy", busy, 1);

    // Release with waitrequest high for three cycles; pending req0 must not be accepted
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("init_ready0", req0_ready, 0);
      chk("init_busy", busy, 1);
    end
    @(negedge clk);
    ram_wr_waitrequest = 1'b0;
    #1;
    chk("init_last_busy", busy, 1);
    chk("init_last_ready0", req0_ready, 0);

    // req0 READ addr 0 (initial value 3)
    run_op(1, 0, 0, 2'd3, 0, 1'b0, 2'd0, 0);
    // req0 WRITE addr 1 data 2, then READ addr 1
    req0_op = 2'b01; req0_address = 1'b1; req0_writedata = 2'd2;
    run_op(1, 0, 0, 2'd0, 1, 1'b1, 2'd2, 0);
    req0_op = 2'b00;
    run_op(1, 0, 0, 2'd2, 0, 1'b1, 2'd0, 0);
    // req1 INCREMENT addr 0 on value 3 wraps to 0
    req1_op = 2'b10; req1_address = 1'b0;
    run_op(0, 1, 1, 2'd3, 1, 1'b0, 2'd0, 0);
    req1_op = 2'b00;
    run_op(0, 1, 1, 2'd0, 0, 1'b0, 2'd0, 0);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    req0_op = 2'b10; req0_address = 1'b1;
    req1_op = 2'b10; req1_address = 1'b0;
    run_op(1, 1, 0, 2'd2, 1, 1'b1, 2'd3, 1);
    run_op(1, 1, 1, 2'd0, 1, 1'b0, 2'd1, 1);
    run_op(1, 1, 0, 2'd3, 1, 1'b1, 2'd0, 1);
    run_op(1, 1, 1, 2'd1, 1, 1'b0, 2'd2, 0);

    // req0 CLEAR addr 0 (value 2) with waitrequest high for two WB cycles
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b11; req0_address = 1'b0;
    #1;
    chk("clr_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    ram_wr_waitrequest = 1'b1;
    #1;
    chk("clr_rd_wr_write", ram_wr_write, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("stall_wr_write", ram_wr_write, 1);
      chk("stall_wr_address", ram_wr_address, 0);
      chk("stall_wr_data", ram_wr_writedata, 0);
      chk("stall_rsp0_valid", rsp0_valid, 0);
      chk("stall_rsp0_hold", rsp0_readdata, last_rsp[0]);
      chk("stall_busy", busy, 1);
    end
    @(negedge clk);
    ram_wr_waitrequest = 1'b0;
    #1;
    chk("clr_rsp0_valid", rsp0_valid, 1);
    chk("clr_rsp0_data", rsp0_readdata, 2);
    chk("clr_wr_write", ram_wr_write, 1);
    chk("clr_wr_data", ram_wr_writedata, 0);
    last_rsp[0] = 2'd2;
    $display("op grant=0 addr=0 old=2 write=1 data=0 (stalled 2 cycles)");
    @(negedge clk);
    #1;
    chk("clr_after_rsp0_valid", rsp0_valid, 0);
    chk("clr_after_busy", busy, 0);
    chk("clr_mem0", mem[0], 0);

    // req0 WRITE addr 1 data 3 abandoned by reset during RD
    req0_valid = 1'b1; req0_op = 2'b01; req0_address = 1'b1; req0_writedata = 2'd3;
    #1;
    chk("abort_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("abort_rd_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_wr_write", ram_wr_write, 0);
    chk("abort_rsp0_valid", rsp0_valid, 0);
    chk("abort_rsp0_data", rsp0_readdata, 0);
    chk("abort_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("abort2_wr_write", ram_wr_write, 0);
    chk("abort2_rsp0_valid", rsp0_valid, 0);
    chk("abort2_rsp1_valid", rsp1_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_init_busy", busy, 1);
    chk("abort_mem1", mem[1], 0);
    $display("op grant=0 addr=1 abandoned by reset");
    last_rsp[0] = 2'd0;
    last_rsp[1] = 2'd0;

    // Pointer back to favouring requester 0 after reset
    req0_op = 2'b00; req0_address = 1'b0;
    req1_op = 2'b01; req1_address = 1'b1; req1_writedata = 2'd1;
    run_op(1, 1, 0, 2'd0, 0, 1'b0, 2'd0, 1);
    run_op(1, 1, 1, 2'd0, 1, 1'b1, 2'd1, 0);
    req0_address = 1'b1;
    run_op(1, 0, 0, 2'd1, 0, 1'b1, 2'd0, 0);
    @(negedge clk);
    #1;
    chk("end_rsp0_valid", rsp0_valid, 0);
    chk("end_rsp0_hold", rsp0_readdata, 1);
    chk("end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_ram_rmw_arbiter.md
STATE_RAM_RMW_ARBITER -- requirements
Module: state_ram_rmw_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 1, width of state-RAM address.
REQ-002 SHALL have parameter DATA_WIDTH, default 2, width of one state word.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and reset_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_address  input  ADDRESS_WIDTH  state location to operate on.
REQ-008 reqN_op  input  2  00 READ, 01 WRITE, 10 INCREMENT, 11 CLEAR.
REQ-009 reqN_writedata  input  DATA_WIDTH  value for WRITE; ignored otherwise.
REQ-010 reqN_ready  output  1  operation accepted this cycle when valid&ready.
REQ-011 rspN_valid  output  1  one-cycle pulse, operation for N complete.
REQ-012 rspN_readdata  output  DATA_WIDTH  state value before the operation.
REQ-013 ram_wr_address / ram_wr_writedata / ram_wr_write  output  ADDRESS_WIDTH / DATA_WIDTH / 1  state-RAM write port.
REQ-014 ram_wr_waitrequest  input  1  state RAM clearing or stalled.
REQ-015 ram_rd0_address  output  ADDRESS_WIDTH; ram_rd0_readdata  input  DATA_WIDTH; RAM read data valid one cycle after address.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be INIT, IDLE, RD, WB.
REQ-018 INIT: all reqN_ready low; go to IDLE in the cycle after ram_wr_waitrequest samples low.
REQ-019 IDLE: if any reqN_valid, grant exactly one, assert its reqN_ready combinationally that cycle, capture address/op/writedata/requester id, go to RD.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; pointer updates only on grant.
REQ-021 ram_rd0_address SHALL equal the captured address in RD and WB, the captured register otherwise.
REQ-022 RD: one cycle, no outputs change except busy; go to WB.
REQ-023 WB: rspN_readdata = ram_rd0_readdata for granted N; new value = writedata (WRITE), old+1 modulo 2^DATA_WIDTH (INCREMENT), 0 (CLEAR), no write (READ).
REQ-024 WB with op != READ: ram_wr_write=1, ram_wr_address=captured address, ram_wr_writedata=new value.
REQ-025 WB with ram_wr_waitrequest high: hold ram_wr_* and stay in WB; rspN_valid only in the cycle the write is accepted (or first WB cycle for READ); then IDLE.
REQ-026 Accept-to-response latency SHALL be 2 cycles without stall; throughput one operation per 3 cycles.
REQ-027 Back-to-back operations on the same address SHALL observe the prior write (the RAM's write bypass guarantees this; no extra forwarding).
REQ-028 reqN_ready SHALL never be high outside IDLE; both ready never high together.
REQ-029 rspN_readdata SHALL hold its last value between pulses.

Reset
REQ-030 Reset values: state INIT, reqN_ready 0, rspN_valid 0, rspN_readdata 0, ram_wr_write 0, ram_wr_address 0, ram_wr_writedata 0, ram_rd0_address 0, busy 1, round-robin pointer favouring requester 0.
REQ-031 Reset asserted mid-operation SHALL abandon it with no write and no response.

Structure
REQ-032 Op encodings and FSM state encodings SHALL live in a shared package state_ram_pkg.
REQ-033 Round-robin grant logic SHALL be one sub-module rr_arbiter2 (two requests, grant one-hot, pointer register).

Verification
REQ-034 Reset release with waitrequest high 3 cycles -> ready stays 0 until IDLE; busy falls the cycle after waitrequest low.
REQ-035 req0 WRITE addr 1 data 2, then req0 READ addr 1 -> second rsp0_readdata = 2; latency 2 cycles each.
REQ-036 req1 INCREMENT addr 0 on value 3 (DATA_WIDTH 2) -> rsp1_readdata 3, RAM written 0 (wrap).
REQ-037 req0 and req1 valid continuously -> grants alternate 0,1,0,1; no response lost.
REQ-038 waitrequest high 2 cycles during WB of CLEAR -> write held stable, rsp pulses once on accept.
REQ-039 reset_n low during RD -> no ram_wr_write, no rsp pulse, returns to INIT.
